// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) writeback path.
// The slots, the CDB output register and the downstream consumers all use cdb_pkt_t.
package cdb_arbiter_pkg;

    localparam int CDB_PD_W   = 6;   // physical register index width
    localparam int CDB_RD_W   = 5;   // architectural register index width
    localparam int CDB_DATA_W = 32;  // result width
    localparam int CDB_ROB_W  = 4;   // ROB index width
    localparam int CDB_NUM_FU = 3;   // 0 = add, 1 = mul, 2 = div
    localparam int CDB_PTR_W  = (CDB_NUM_FU > 1) ? $clog2(CDB_NUM_FU) : 1;

    typedef struct packed {
        logic [CDB_PD_W-1:0]   pd;
        logic [CDB_RD_W-1:0]   rd;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_ROB_W-1:0]  rob;
        logic                  regf_we;
    } cdb_pkt_t;

    // Round-robin successor of a grant index, wrapping at the last unit.
    function automatic logic [CDB_PTR_W-1:0] rr_next(input logic [CDB_PTR_W-1:0] g);
        if (g == CDB_PTR_W'(CDB_NUM_FU - 1)) begin
            return '0;
        end
        return g + CDB_PTR_W'(1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Purely combinational round-robin arbiter: searches upward from ptr_i with
// wrap-around and grants the first requester found. Reusable for issue ports.
module cdb_arbiter_rr #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_valid_o
);

    // Scan N positions starting at the pointer; the first request wins.
    always_comb begin
        int idx;
        idx         = 0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_i) + off) % N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per functional unit, round-robin selection of
// one held result per cycle, broadcast through a registered CDB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int PHYS_REG_BITS = CDB_PD_W,
    parameter int ROB_IDX_BITS  = CDB_ROB_W,
    parameter int NUM_FU        = CDB_NUM_FU
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NUM_FU-1:0]               fu_valid_i,
    output logic [NUM_FU-1:0]               fu_ready_o,
    input  logic [NUM_FU*PHYS_REG_BITS-1:0] fu_pd_i,
    input  logic [NUM_FU*5-1:0]             fu_rd_i,
    input  logic [NUM_FU*32-1:0]            fu_data_i,
    input  logic [NUM_FU*ROB_IDX_BITS-1:0]  fu_rob_i,
    input  logic [NUM_FU-1:0]               fu_regf_we_i,
    output logic                            cdb_valid_o,
    output logic [PHYS_REG_BITS-1:0]        cdb_pd_o,
    output logic [4:0]                      cdb_rd_o,
    output logic [31:0]                     cdb_data_o,
    output logic [ROB_IDX_BITS-1:0]         cdb_rob_o,
    output logic                            cdb_regf_we_o,
    output logic [NUM_FU-1:0]               cdb_src_o
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] held_q;
    cdb_pkt_t          slot_pkt [NUM_FU];
    cdb_pkt_t          in_pkt   [NUM_FU];
    logic [NUM_FU-1:0] grant;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [NUM_FU-1:0] accept;
    cdb_pkt_t          gnt_pkt;

    logic [PW-1:0]     rr_ptr_q;
    cdb_pkt_t          cdb_q;
    logic              cdb_valid_q;
    logic [NUM_FU-1:0] cdb_src_q;

    cdb_arbiter_rr #(.N(NUM_FU), .IW(PW)) u_rr (
        .req_i       (held_q),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (grant),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A slot can take a new result when empty or when it drains this cycle;
    // flush blocks intake, and reset reports every slot as free.
    always_comb begin
        if (!rst_ni) begin
            fu_ready_o = '1;
        end else if (flush_i) begin
            fu_ready_o = '0;
        end else begin
            fu_ready_o = ~held_q | grant;
        end
    end

    assign accept = fu_valid_i & fu_ready_o;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
            cdb_pkt_t slot_q;
            logic     held_bit_q;

            assign in_pkt[gi] = '{
                pd:      fu_pd_i[gi*PHYS_REG_BITS +: PHYS_REG_BITS],
                rd:      fu_rd_i[gi*5 +: 5],
                data:    fu_data_i[gi*32 +: 32],
                rob:     fu_rob_i[gi*ROB_IDX_BITS +: ROB_IDX_BITS],
                regf_we: fu_regf_we_i[gi]
            };

            // Holding slot: load on accept (refill wins over drain), clear on grant or flush.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    held_bit_q <= 1'b0;
                    slot_q     <= '0;
                end else if (flush_i) begin
                    held_bit_q <= 1'b0;
                end else if (accept[gi]) begin
                    held_bit_q <= 1'b1;
                    slot_q     <= in_pkt[gi];
                end else if (grant[gi]) begin
                    held_bit_q <= 1'b0;
                end
            end

            assign held_q[gi]   = held_bit_q;
            assign slot_pkt[gi] = slot_q;
        end
    endgenerate

    // Select the granted slot's contents with a one-hot mux.
    always_comb begin
        gnt_pkt = slot_pkt[0];
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                gnt_pkt = slot_pkt[i];
            end
        end
    end

    // CDB output register and round-robin pointer; fields hold when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else if (flush_i) begin
            cdb_valid_q <= 1'b0;
        end else if (gnt_valid) begin
            cdb_q         <= gnt_pkt;
            // x0 is never written, but the result still completes in the ROB.
            cdb_q.regf_we <= gnt_pkt.regf_we && (gnt_pkt.rd != '0);
            cdb_valid_q   <= 1'b1;
            cdb_src_q     <= grant;
            rr_ptr_q      <= rr_next(gnt_idx);
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_pd_o      = cdb_q.pd;
    assign cdb_rd_o      = cdb_q.rd;
    assign cdb_data_o    = cdb_q.data;
    assign cdb_rob_o     = cdb_q.rob;
    assign cdb_regf_we_o = cdb_q.regf_we;
    assign cdb_src_o     = cdb_src_q;

endmodule
